// File: rtl/zymason_seg_pkg.sv
// zymason_seg_pkg: shared types and default parameters for the segment scroller.
//   state_e   : controller mode, encoding is visible on mode_out
//   DEF_*     : default build parameters
//   ceil_div  : integer ceiling division used to size the write-chunk counter
package zymason_seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SCAN  = 2'b01,
      ST_WRITE = 2'b10
   } state_e;

   localparam int unsigned DEF_NUM_DIGITS = 10;
   localparam int unsigned DEF_SEG_W      = 7;
   localparam int unsigned DEF_NIB_W      = 4;
   localparam int unsigned DEF_PRE_W      = 9;
   localparam int unsigned DEF_SPD_W      = 4;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/zymason_seg_scroller_if.sv
// zymason_seg_scroller_if: control/data bundle between the pin-level front end
// and the segment scroller.
//   master : drives rw, wr_valid, wr_data, clr, dir, spd; observes the outputs
//   slave  : the scroller; drives seg_out, dig_idx, len, full, ovf, mode_out
interface zymason_seg_scroller_if #(
   parameter int unsigned NUM_DIGITS = zymason_seg_pkg::DEF_NUM_DIGITS,
   parameter int unsigned SEG_W      = zymason_seg_pkg::DEF_SEG_W,
   parameter int unsigned NIB_W      = zymason_seg_pkg::DEF_NIB_W,
   parameter int unsigned SPD_W      = zymason_seg_pkg::DEF_SPD_W
);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned LEN_W = $clog2(NUM_DIGITS + 1);

   logic             rw;
   logic             wr_valid;
   logic [NIB_W-1:0] wr_data;
   logic             clr;
   logic             dir;
   logic [SPD_W-1:0] spd;

   logic [SEG_W-1:0] seg_out;
   logic [IDX_W-1:0] dig_idx;
   logic [LEN_W-1:0] len;
   logic             full;
   logic             ovf;
   logic [1:0]       mode_out;

   modport master (
      output rw, wr_valid, wr_data, clr, dir, spd,
      input  seg_out, dig_idx, len, full, ovf, mode_out
   );

   modport slave (
      input  rw, wr_valid, wr_data, clr, dir, spd,
      output seg_out, dig_idx, len, full, ovf, mode_out
   );

endinterface

// File: rtl/zymason_seg_tickgen.sv
// zymason_seg_tickgen: scan-rate tick generator.
//   clock, reset_n : system clock, async active-low reset
//   spd            : scan period in prescaler wraps, 0 = paused
//   restart        : clears the rate counter (scan entry)
//   tick           : registered one-cycle scan step pulse
module zymason_seg_tickgen #(
   parameter int unsigned PRE_W = zymason_seg_pkg::DEF_PRE_W,
   parameter int unsigned SPD_W = zymason_seg_pkg::DEF_SPD_W
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [SPD_W-1:0] spd,
   input  logic             restart,
   output logic             tick
);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [SPD_W-1:0] rate_q, rate_d;
   logic             tick_q, tick_d;
   logic             wrap_c;

   // Prescaler free-runs; rate counter advances on each wrap and ticks on
   // reaching spd-1 (>= so a lowered spd ticks at the next wrap).
   always_comb begin
      pre_d  = pre_q + PRE_W'(1);
      wrap_c = (pre_q == '1);
      rate_d = rate_q;
      tick_d = 1'b0;
      if (restart || (spd == '0)) begin
         rate_d = '0;
      end else if (wrap_c) begin
         if (rate_q >= (spd - SPD_W'(1))) begin
            tick_d = 1'b1;
            rate_d = '0;
         end else begin
            rate_d = rate_q + SPD_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pre_q  <= '0;
         rate_q <= '0;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         rate_q <= rate_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/zymason_seg_scroller.sv
// zymason_seg_scroller: N-digit segment-pattern buffer, loaded a nibble at a
// time in WRITE mode and scanned onto one segment output in SCAN mode.
//   clock, reset_n : system clock, async active-low reset
//   bus (slave)    : rw/wr_valid/wr_data/clr/dir/spd in;
//                    seg_out/dig_idx/len/full/ovf/mode_out out (all registered)
module zymason_seg_scroller #(
   parameter int unsigned NUM_DIGITS = zymason_seg_pkg::DEF_NUM_DIGITS,
   parameter int unsigned SEG_W      = zymason_seg_pkg::DEF_SEG_W,
   parameter int unsigned NIB_W      = zymason_seg_pkg::DEF_NIB_W,
   parameter int unsigned PRE_W      = zymason_seg_pkg::DEF_PRE_W,
   parameter int unsigned SPD_W      = zymason_seg_pkg::DEF_SPD_W
) (
   input  logic                   clock,
   input  logic                   reset_n,
   zymason_seg_scroller_if.slave  bus
);
   import zymason_seg_pkg::*;

   localparam int unsigned CHUNKS = ceil_div(SEG_W, NIB_W);
   localparam int unsigned K_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int unsigned WIDE_W = CHUNKS * NIB_W;
   localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
   localparam int unsigned LEN_W  = $clog2(NUM_DIGITS + 1);
   localparam logic [NIB_W-1:0] NIB_MASK = '1;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             full_q, full_d;
   logic             ovf_q, ovf_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [SEG_W-1:0] stg_q, stg_d;
   logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [SEG_W-1:0] seg_out_q, seg_out_d;
   logic [IDX_W-1:0] dig_idx_q, dig_idx_d;

   logic [SEG_W-1:0] mem [NUM_DIGITS];

   logic             mem_we_c;
   logic [SEG_W-1:0] stg_new_c;
   int unsigned      sh_c;
   logic             restart_c;
   logic             scan_tick;

   zymason_seg_tickgen #(
      .PRE_W (PRE_W),
      .SPD_W (SPD_W)
   ) u_tickgen (
      .clock   (clock),
      .reset_n (reset_n),
      .spd     (bus.spd),
      .restart (restart_c),
      .tick    (scan_tick)
   );

   // Next-state, buffer bookkeeping and registered output values.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      ovf_d     = ovf_q;
      k_d       = k_q;
      stg_d     = stg_q;
      rd_ptr_d  = rd_ptr_q;
      mem_we_c  = 1'b0;
      seg_out_d = '0;
      dig_idx_d = '0;

      // Merge the incoming nibble at chunk k; bits past SEG_W fall off.
      sh_c      = 32'(k_q) * NIB_W;
      stg_new_c = SEG_W'((WIDE_W'(stg_q) & ~(WIDE_W'(NIB_MASK) << sh_c)) |
                         (WIDE_W'(bus.wr_data) << sh_c));

      // clr beats a coincident chunk.
      if (bus.clr) begin
         len_d = '0;
         ovf_d = 1'b0;
         k_d   = '0;
         stg_d = '0;
      end else if ((state_q == ST_WRITE) && bus.wr_valid) begin
         if (k_q == K_W'(CHUNKS - 1)) begin
            k_d   = '0;
            stg_d = '0;
            if (full_q) begin
               ovf_d = 1'b1;
            end else begin
               mem_we_c = 1'b1;
               len_d    = len_q + LEN_W'(1);
            end
         end else begin
            k_d   = k_q + K_W'(1);
            stg_d = stg_new_c;
         end
      end

      state_d = bus.rw ? ST_WRITE : ((len_d != '0) ? ST_SCAN : ST_IDLE);

      // Any partial digit is lost outside WRITE; entry starts from chunk 0.
      if ((state_d != ST_WRITE) || (state_q != ST_WRITE)) begin
         k_d   = '0;
         stg_d = '0;
      end

      restart_c = (state_d == ST_SCAN) && (state_q != ST_SCAN);

      // Read pointer wraps at len, not at the buffer depth.
      if (restart_c) begin
         rd_ptr_d = bus.dir ? IDX_W'(len_d - LEN_W'(1)) : '0;
      end else if ((state_q == ST_SCAN) && scan_tick) begin
         if (!bus.dir) begin
            rd_ptr_d = (rd_ptr_q == IDX_W'(len_q - LEN_W'(1))) ? '0 : rd_ptr_q + IDX_W'(1);
         end else begin
            rd_ptr_d = (rd_ptr_q == '0) ? IDX_W'(len_q - LEN_W'(1)) : rd_ptr_q - IDX_W'(1);
         end
      end

      full_d = (len_d == LEN_W'(NUM_DIGITS));

      case (state_q)
         ST_SCAN: begin
            seg_out_d = mem[rd_ptr_q];
            dig_idx_d = rd_ptr_q;
         end
         ST_WRITE: begin
            seg_out_d = stg_q;
            dig_idx_d = (len_q >= LEN_W'(NUM_DIGITS - 1)) ? IDX_W'(NUM_DIGITS - 1)
                                                          : IDX_W'(len_q);
         end
         default: begin
            seg_out_d = '0;
            dig_idx_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         len_q     <= '0;
         full_q    <= 1'b0;
         ovf_q     <= 1'b0;
         k_q       <= '0;
         stg_q     <= '0;
         rd_ptr_q  <= '0;
         seg_out_q <= '0;
         dig_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         full_q    <= full_d;
         ovf_q     <= ovf_d;
         k_q       <= k_d;
         stg_q     <= stg_d;
         rd_ptr_q  <= rd_ptr_d;
         seg_out_q <= seg_out_d;
         dig_idx_q <= dig_idx_d;
      end
   end

   // Pattern storage, deliberately not reset.
   always_ff @(posedge clock) begin
      if (mem_we_c) begin
         mem[IDX_W'(len_q)] <= stg_new_c;
      end
   end

   assign bus.seg_out  = seg_out_q;
   assign bus.dig_idx  = dig_idx_q;
   assign bus.len      = len_q;
   assign bus.full     = full_q;
   assign bus.ovf      = ovf_q;
   assign bus.mode_out = state_q;

endmodule

// File: tb/tb_zymason_seg_scroller.sv
// tb_zymason_seg_scroller: directed self-checking bench for zymason_seg_scroller
// (NUM_DIGITS=4, SEG_W=7, NIB_W=4, PRE_W=2).
module tb_zymason_seg_scroller;

   logic clock;
   logic reset_n;
   int   n_cmp;
   int   n_bad;

   zymason_seg_scroller_if #(.NUM_DIGITS(4), .SEG_W(7), .NIB_W(4), .SPD_W(4)) bus ();

   zymason_seg_scroller #(
      .NUM_DIGITS (4),
      .SEG_W      (7),
      .NIB_W      (4),
      .PRE_W      (2),
      .SPD_W      (4)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr_chunk(input logic [3:0] d);
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      step();
      bus.wr_valid = 1'b0;
      bus.wr_data  = 4'h0;
   endtask

   // Steps until dig_idx leaves old (bounded); n = steps taken.
   task automatic wait_dig_change(input logic [1:0] old, input int bound,
                                  output logic [1:0] nv, output int n);
      n = 0;
      while ((n < bound) && (bus.dig_idx === old)) begin
         step();
         n++;
      end
      nv = bus.dig_idx;
   endtask

   task automatic test_reset();
      n_cmp++; if (bus.seg_out !== 7'h00) begin n_bad++; $display("FAIL reset_seg: got %h want 00", bus.seg_out); end
      n_cmp++; if (bus.dig_idx !== 2'd0) begin n_bad++; $display("FAIL reset_dig: got %0d want 0", bus.dig_idx); end
      n_cmp++; if (bus.len !== 3'd0) begin n_bad++; $display("FAIL reset_len: got %0d want 0", bus.len); end
      n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
      n_cmp++; if (bus.mode_out !== 2'b00) begin n_bad++; $display("FAIL reset_mode: got %b want 00", bus.mode_out); end
   endtask

   task automatic test_load_scan();
      logic [6:0] exp;
      int n;
      bus.rw = 1'b1;
      step();
      n_cmp++; if (bus.mode_out !== 2'b10) begin n_bad++; $display("FAIL load_mode_wr: got %b want 10", bus.mode_out); end
      wr_chunk(4'h3);
      step();
      n_cmp++; if (bus.seg_out !== 7'h03) begin n_bad++; $display("FAIL load_staging: got %h want 03", bus.seg_out); end
      n_cmp++; if (bus.dig_idx !== 2'd0) begin n_bad++; $display("FAIL load_wr_idx: got %0d want 0", bus.dig_idx); end
      wr_chunk(4'h5);
      n_cmp++; if (bus.len !== 3'd1) begin n_bad++; $display("FAIL load_len1: got %0d want 1", bus.len); end
      wr_chunk(4'hF);
      wr_chunk(4'h2);
      n_cmp++; if (bus.len !== 3'd2) begin n_bad++; $display("FAIL load_len2: got %0d want 2", bus.len); end
      n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL load_full: got %b want 0", bus.full); end
      bus.rw  = 1'b0;
      bus.spd = 4'd1;
      bus.dir = 1'b0;
      step();
      n_cmp++; if (bus.mode_out !== 2'b01) begin n_bad++; $display("FAIL load_mode_scan: got %b want 01", bus.mode_out); end
      step();
      n_cmp++; if (bus.seg_out !== 7'h53) begin n_bad++; $display("FAIL load_first: got %h want 53", bus.seg_out); end
      n = 0;
      while ((n < 10) && (bus.seg_out === 7'h53)) begin
         step();
         n++;
      end
      // Steady pattern: 4 cycles of 2F, 4 of 53, then 2F again.
      for (int i = 0; i < 9; i++) begin
         if (i > 0) step();
         exp = ((i < 4) || (i == 8)) ? 7'h2F : 7'h53;
         n_cmp++;
         if (bus.seg_out !== exp) begin
            n_bad++;
            $display("FAIL load_scan_seq[%0d]: got %h want %h", i, bus.seg_out, exp);
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] digs [5];
      digs = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      bus.clr = 1'b1;
      step();
      bus.clr = 1'b0;
      n_cmp++; if (bus.len !== 3'd0) begin n_bad++; $display("FAIL ovf_preclr_len: got %0d want 0", bus.len); end
      n_cmp++; if (bus.mode_out !== 2'b00) begin n_bad++; $display("FAIL ovf_preclr_mode: got %b want 00", bus.mode_out); end
      step();
      n_cmp++; if (bus.seg_out !== 7'h00) begin n_bad++; $display("FAIL ovf_idle_seg: got %h want 00", bus.seg_out); end
      bus.rw = 1'b1;
      step();
      for (int d = 0; d < 5; d++) begin
         wr_chunk(digs[d][3:0]);
         wr_chunk(digs[d][7:4]);
         if (d == 3) begin
            n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL ovf_full4: got %b want 1", bus.full); end
            n_cmp++; if (bus.len !== 3'd4) begin n_bad++; $display("FAIL ovf_len4: got %0d want 4", bus.len); end
            n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", bus.ovf); end
         end
      end
      n_cmp++; if (bus.ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", bus.ovf); end
      n_cmp++; if (bus.len !== 3'd4) begin n_bad++; $display("FAIL ovf_len5: got %0d want 4", bus.len); end
      step();
      n_cmp++; if (bus.dig_idx !== 2'd3) begin n_bad++; $display("FAIL ovf_idx_sat: got %0d want 3", bus.dig_idx); end
      bus.rw  = 1'b0;
      bus.clr = 1'b1;
      step();
      bus.clr = 1'b0;
      n_cmp++; if (bus.len !== 3'd0) begin n_bad++; $display("FAIL ovf_clr_len: got %0d want 0", bus.len); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr_ovf: got %b want 0", bus.ovf); end
      n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL ovf_clr_full: got %b want 0", bus.full); end
      n_cmp++; if (bus.mode_out !== 2'b00) begin n_bad++; $display("FAIL ovf_clr_mode: got %b want 00", bus.mode_out); end
   endtask

   task automatic test_partial_discard();
      bus.rw = 1'b1;
      step();
      wr_chunk(4'h1); wr_chunk(4'h6);
      wr_chunk(4'h2); wr_chunk(4'h7);
      wr_chunk(4'h3); wr_chunk(4'h0);
      n_cmp++; if (bus.len !== 3'd3) begin n_bad++; $display("FAIL part_len3: got %0d want 3", bus.len); end
      wr_chunk(4'hE);
      bus.rw  = 1'b0;
      bus.spd = 4'd0;
      bus.dir = 1'b0;
      step();
      n_cmp++; if (bus.len !== 3'd3) begin n_bad++; $display("FAIL part_len_kept: got %0d want 3", bus.len); end
      n_cmp++; if (bus.mode_out !== 2'b01) begin n_bad++; $display("FAIL part_mode: got %b want 01", bus.mode_out); end
      step();
      n_cmp++; if (bus.seg_out !== 7'h61) begin n_bad++; $display("FAIL part_seg: got %h want 61", bus.seg_out); end
      n_cmp++; if (bus.dig_idx !== 2'd0) begin n_bad++; $display("FAIL part_idx: got %0d want 0", bus.dig_idx); end
      bus.rw = 1'b1;
      step();
      step();
      n_cmp++; if (bus.seg_out !== 7'h00) begin n_bad++; $display("FAIL part_stg_clear: got %h want 00", bus.seg_out); end
      wr_chunk(4'h1);
      step();
      n_cmp++; if (bus.seg_out !== 7'h01) begin n_bad++; $display("FAIL part_k_restart: got %h want 01", bus.seg_out); end
      bus.rw = 1'b0;
      step();
      n_cmp++; if (bus.len !== 3'd3) begin n_bad++; $display("FAIL part_len_after: got %0d want 3", bus.len); end
   endtask

   task automatic test_descending();
      logic [1:0] nv;
      int n;
      bus.rw  = 1'b1;
      bus.dir = 1'b1;
      bus.spd = 4'd1;
      step();
      bus.rw = 1'b0;
      step();
      step();
      n_cmp++; if (bus.dig_idx !== 2'd2) begin n_bad++; $display("FAIL desc_start: got %0d want 2", bus.dig_idx); end
      n_cmp++; if (bus.seg_out !== 7'h03) begin n_bad++; $display("FAIL desc_seg: got %h want 03", bus.seg_out); end
      wait_dig_change(2'd2, 12, nv, n);
      n_cmp++; if (nv !== 2'd1) begin n_bad++; $display("FAIL desc_step1: got %0d want 1", nv); end
      wait_dig_change(2'd1, 12, nv, n);
      n_cmp++; if (nv !== 2'd0) begin n_bad++; $display("FAIL desc_step2: got %0d want 0", nv); end
      wait_dig_change(2'd0, 12, nv, n);
      n_cmp++; if (nv !== 2'd2) begin n_bad++; $display("FAIL desc_wrap: got %0d want 2", nv); end
      bus.spd = 4'd0;
      repeat (3) step();
      n_cmp++; if (bus.dig_idx !== 2'd2) begin n_bad++; $display("FAIL desc_pause_a: got %0d want 2", bus.dig_idx); end
      repeat (20) step();
      n_cmp++; if (bus.dig_idx !== 2'd2) begin n_bad++; $display("FAIL desc_pause_b: got %0d want 2", bus.dig_idx); end
      bus.spd = 4'd3;
      wait_dig_change(2'd2, 40, nv, n);
      n_cmp++; if (nv !== 2'd1) begin n_bad++; $display("FAIL desc_resume: got %0d want 1", nv); end
      wait_dig_change(2'd1, 40, nv, n);
      n_cmp++; if (nv !== 2'd0) begin n_bad++; $display("FAIL desc_resume2: got %0d want 0", nv); end
      n_cmp++; if (n !== 12) begin n_bad++; $display("FAIL desc_period: got %0d want 12", n); end
   endtask

   task automatic test_clr_collision();
      bus.rw = 1'b1;
      step();
      wr_chunk(4'h5);
      bus.clr      = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 4'h7;
      step();
      bus.clr      = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = 4'h0;
      n_cmp++; if (bus.len !== 3'd0) begin n_bad++; $display("FAIL coll_len: got %0d want 0", bus.len); end
      step();
      n_cmp++; if (bus.seg_out !== 7'h00) begin n_bad++; $display("FAIL coll_stg: got %h want 00", bus.seg_out); end
      n_cmp++; if (bus.dig_idx !== 2'd0) begin n_bad++; $display("FAIL coll_idx: got %0d want 0", bus.dig_idx); end
      wr_chunk(4'h9);
      step();
      n_cmp++; if (bus.seg_out !== 7'h09) begin n_bad++; $display("FAIL coll_k0: got %h want 09", bus.seg_out); end
      wr_chunk(4'h1);
      n_cmp++; if (bus.len !== 3'd1) begin n_bad++; $display("FAIL coll_len1: got %0d want 1", bus.len); end
   endtask

   task automatic test_reset_mid();
      bus.rw  = 1'b0;
      bus.dir = 1'b0;
      bus.spd = 4'd1;
      step();
      step();
      n_cmp++; if (bus.seg_out !== 7'h19) begin n_bad++; $display("FAIL rst_pre_seg: got %h want 19", bus.seg_out); end
      n_cmp++; if (bus.mode_out !== 2'b01) begin n_bad++; $display("FAIL rst_pre_mode: got %b want 01", bus.mode_out); end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++; if (bus.seg_out !== 7'h00) begin n_bad++; $display("FAIL rst_seg: got %h want 00", bus.seg_out); end
      n_cmp++; if (bus.dig_idx !== 2'd0) begin n_bad++; $display("FAIL rst_idx: got %0d want 0", bus.dig_idx); end
      n_cmp++; if (bus.len !== 3'd0) begin n_bad++; $display("FAIL rst_len: got %0d want 0", bus.len); end
      n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", bus.full); end
      n_cmp++; if (bus.ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
      n_cmp++; if (bus.mode_out !== 2'b00) begin n_bad++; $display("FAIL rst_mode: got %b want 00", bus.mode_out); end
      step();
      reset_n = 1'b1;
      step();
      n_cmp++; if (bus.len !== 3'd0) begin n_bad++; $display("FAIL rst_after_len: got %0d want 0", bus.len); end
      n_cmp++; if (bus.mode_out !== 2'b00) begin n_bad++; $display("FAIL rst_after_mode: got %b want 00", bus.mode_out); end
   endtask

   initial begin
      n_cmp        = 0;
      n_bad        = 0;
      reset_n      = 1'b0;
      bus.rw       = 1'b0;
      bus.wr_valid = 1'b0;
      bus.wr_data  = 4'h0;
      bus.clr      = 1'b0;
      bus.dir      = 1'b0;
      bus.spd      = 4'd0;
      step();
      step();
      test_reset();
      reset_n = 1'b1;
      step();
      test_load_scan();
      test_overflow();
      test_partial_discard();
      test_descending();
      test_clr_collision();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
